// File: rtl/sm9_mult_io.sv
// sm9_mult_io
//   Word-serial front end for the SM9 scalar multiplication core.
//   Collects k, x and y as 32-bit words (most-significant word first) into
//   256-bit operand registers. It then pulses the core reset, runs the core
//   until core_sign rises, and streams x1 then y1 back out as 32-bit words.
//   A zero scalar is never launched, because the core would not terminate on
//   it. Instead an all-zero result is returned with err set.
//
// Ports
//   clk                        rising-edge clock
//   rst_b                      synchronous reset, active high (legacy name)
//   wr_valid/wr_ready/wr_data  input word handshake (24 words: k, x, y)
//   rd_valid/rd_ready/rd_data  output word handshake (16 words: x1, y1)
//   busy                       transaction in progress (CHECK .. last UNLOAD word)
//   err                        current result invalid because k == 0
//   core_rst_b                 active-low core reset
//   core_en                    core start, held for the whole run
//   core_l/core_x0/core_y0     operand registers driven to the core
//   core_x1/core_y1            core result
//   core_sign                  core done level, sticky until the core is reset
module sm9_mult_io (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [31:0]  wr_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [31:0]  rd_data,
  output logic         busy,
  output logic         err,
  output logic         core_rst_b,
  output logic         core_en,
  output logic [255:0] core_l,
  output logic [255:0] core_x0,
  output logic [255:0] core_y0,
  input  logic [255:0] core_x1,
  input  logic [255:0] core_y1,
  input  logic         core_sign
);

  typedef enum logic [2:0] {
    LOAD,
    CHECK,
    CRST,
    RUN,
    CAPTURE,
    UNLOAD
  } state_t;

  state_t       state;
  logic [4:0]   in_cnt;
  logic [3:0]   out_cnt;
  logic         crst_cnt;
  logic [255:0] res_x1;
  logic [255:0] res_y1;

  // Handshake and status outputs are pure decodes of the state register,
  // so there is no combinational path from wr_valid or rd_ready.
  assign wr_ready = (state == LOAD);
  assign rd_valid = (state == UNLOAD);
  assign busy     = (state != LOAD);

  // The result registers act as one 512-bit shift register {x1, y1}.
  // The word on rd_data is always the top word.
  assign rd_data  = res_x1[255:224];

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state      <= LOAD;
      in_cnt     <= '0;
      out_cnt    <= '0;
      crst_cnt   <= 1'b0;
      err        <= 1'b0;
      core_en    <= 1'b0;
      core_rst_b <= 1'b0;
      core_l     <= '0;
      core_x0    <= '0;
      core_y0    <= '0;
      res_x1     <= '0;
      res_y1     <= '0;
    end else begin
      case (state)
        LOAD: begin
          core_rst_b <= 1'b1;
          core_en    <= 1'b0;
          if (wr_valid) begin
            if (in_cnt == 5'd0) begin
              err <= 1'b0;
            end
            // Shifting in from the bottom leaves word 0 in bits [255:224]
            // once all eight words of an operand have arrived.
            if (in_cnt < 5'd8) begin
              core_l  <= {core_l[223:0], wr_data};
            end else if (in_cnt < 5'd16) begin
              core_x0 <= {core_x0[223:0], wr_data};
            end else begin
              core_y0 <= {core_y0[223:0], wr_data};
            end
            if (in_cnt == 5'd23) begin
              in_cnt <= '0;
              state  <= CHECK;
            end else begin
              in_cnt <= in_cnt + 5'd1;
            end
          end
        end

        CHECK: begin
          if (core_l == '0) begin
            res_x1  <= '0;
            res_y1  <= '0;
            err     <= 1'b1;
            out_cnt <= '0;
            state   <= UNLOAD;
          end else begin
            core_rst_b <= 1'b0;
            crst_cnt   <= 1'b0;
            state      <= CRST;
          end
        end

        // Two cycles of core reset, which clears the sticky core_sign from the
        // previous run before the core is enabled again.
        CRST: begin
          if (crst_cnt) begin
            core_rst_b <= 1'b1;
            core_en    <= 1'b1;
            state      <= RUN;
          end else begin
            crst_cnt <= 1'b1;
          end
        end

        RUN: begin
          if (core_sign) begin
            core_en <= 1'b0;
            state   <= CAPTURE;
          end
        end

        CAPTURE: begin
          res_x1  <= core_x1;
          res_y1  <= core_y1;
          out_cnt <= '0;
          state   <= UNLOAD;
        end

        UNLOAD: begin
          if (rd_ready) begin
            {res_x1, res_y1} <= {res_x1[223:0], res_y1, 32'h0000_0000};
            if (out_cnt == 4'd15) begin
              out_cnt <= '0;
              state   <= LOAD;
            end else begin
              out_cnt <= out_cnt + 4'd1;
            end
          end
        end

        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm9_mult_io.sv
// tb_sm9_mult_io
//   Directed bench for sm9_mult_io. A behavioural core raises core_sign 50
//   cycles after core_en rises and returns x1 = l + x0, y1 = y0. Those
//   results are latched at completion and cleared by core_rst_b.
//   Expected output words are hand-computed constants.
module tb_sm9_mult_io;

  logic         clk;
  logic         rst_b;
  logic         wr_valid;
  logic         wr_ready;
  logic [31:0]  wr_data;
  logic         rd_valid;
  logic         rd_ready;
  logic [31:0]  rd_data;
  logic         busy;
  logic         err;
  logic         core_rst_b;
  logic         core_en;
  logic [255:0] core_l;
  logic [255:0] core_x0;
  logic [255:0] core_y0;
  logic [255:0] core_x1;
  logic [255:0] core_y1;
  logic         core_sign;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [255:0] X8   = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
  localparam logic [255:0] X8P5 = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_0000000D;
  localparam logic [255:0] X8P7 = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_0000000F;
  localparam logic [255:0] X8PC = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000008_00000007;
  localparam logic [255:0] YP   = 256'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF_DEADBEEF_CAFEF00D_0BADF00D_FFFFFFFF;

  sm9_mult_io dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .busy       (busy),
    .err        (err),
    .core_rst_b (core_rst_b),
    .core_en    (core_en),
    .core_l     (core_l),
    .core_x0    (core_x0),
    .core_y0    (core_y0),
    .core_x1    (core_x1),
    .core_y1    (core_y1),
    .core_sign  (core_sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural scalar multiplication core
  int unsigned  run_cnt = 0;
  logic         m_sign  = 1'b0;
  logic [255:0] m_x1    = '0;
  logic [255:0] m_y1    = '0;

  assign core_sign = m_sign;
  assign core_x1   = m_x1;
  assign core_y1   = m_y1;

  always @(posedge clk) begin
    if (core_rst_b === 1'b0) begin
      m_sign  <= 1'b0;
      run_cnt <= 0;
      m_x1    <= '0;
      m_y1    <= '0;
    end else if (core_en === 1'b1 && !m_sign) begin
      if (run_cnt == 49) begin
        m_sign <= 1'b1;
        m_x1   <= core_l + core_x0;
        m_y1   <= core_y0;
      end else begin
        run_cnt <= run_cnt + 1;
      end
    end
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge one cycle after release.
  task automatic do_reset();
    rst_b    = 1'b1;
    rd_ready = 1'b0;
    @(negedge clk);
    check1("rst_core_rst_b", core_rst_b, 1'b0);
    check1("rst_core_en", core_en, 1'b0);
    check1("rst_rd_valid", rd_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_err", err, 1'b0);
    wr_valid = 1'b0;
    rst_b    = 1'b0;
    @(negedge clk);
    check1("rel_wr_ready", wr_ready, 1'b1);
    check1("rel_core_en", core_en, 1'b0);
    check1("rel_core_rst_b", core_rst_b, 1'b1);
  endtask

  // Sends words 0..nw-1 of {k,x,y}. Returns just after the edge that accepts
  // the last word, with wr_valid still high.
  task automatic load(input logic [255:0] k, input logic [255:0] x, input logic [255:0] y,
                      input bit gaps, input int nw);
    logic [767:0] all;
    all = {k, x, y};
    for (int i = 0; i < nw; i++) begin
      @(negedge clk);
      if (gaps) begin
        wr_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      if (i == 1) check1("err_clear", err, 1'b0);
      check1("load_wr_ready", wr_ready, 1'b1);
      wr_valid = 1'b1;
      wr_data  = all[767-32*i -: 32];
      @(posedge clk);
    end
  endtask

  // Follows the control sequence after the last word.
  // Returns at the negedge of the first rd_valid cycle.
  task automatic wait_result(input bit zero_k);
    int cyc;
    int en_cyc;
    bit seen;
    @(negedge clk);
    wr_valid = 1'b0;
    check1("check_busy", busy, 1'b1);
    check1("check_wr_ready", wr_ready, 1'b0);
    if (zero_k) begin
      @(negedge clk);
      check1("zk_rd_valid", rd_valid, 1'b1);
      check1("zk_core_en", core_en, 1'b0);
      check1("zk_core_rst_b", core_rst_b, 1'b1);
    end else begin
      @(negedge clk);
      check1("crst1", core_rst_b, 1'b0);
      check1("crst1_en", core_en, 1'b0);
      @(negedge clk);
      check1("crst2", core_rst_b, 1'b0);
      @(negedge clk);
      check1("crst_end", core_rst_b, 1'b1);
      check1("en_rise", core_en, 1'b1);
      cyc    = 4;
      en_cyc = 1;
      seen   = 1'b0;
      while (!seen && cyc < 300) begin
        @(negedge clk);
        cyc++;
        if (core_en) en_cyc++;
        if (rd_valid) seen = 1'b1;
      end
      check32("run_latency", cyc, 32'd56);
      check32("en_cycles", en_cyc, 32'd51);
    end
  endtask

  // Consumes nw words; with throttle, holds rd_ready low 3 cycles per word.
  task automatic unload(input logic [255:0] ex, input logic [255:0] ey, input bit throttle,
                        input logic eerr, input int nw);
    logic [511:0] cat;
    logic [31:0]  w;
    cat = {ex, ey};
    for (int i = 0; i < nw; i++) begin
      w = cat[511-32*i -: 32];
      if (throttle) begin
        rd_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          check1("stall_valid", rd_valid, 1'b1);
          check32("stall_data", rd_data, w);
          @(negedge clk);
        end
      end
      rd_ready = 1'b1;
      check1("rd_valid", rd_valid, 1'b1);
      check32("rd_data", rd_data, w);
      check1("unload_err", err, eerr);
      @(posedge clk);
      @(negedge clk);
    end
    if (nw == 16) begin
      rd_ready = 1'b0;
      check1("done_wr_ready", wr_ready, 1'b1);
      check1("done_rd_valid", rd_valid, 1'b0);
      check1("done_busy", busy, 1'b0);
    end
  endtask

  initial begin
    rst_b    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    do_reset();

    // Basic transfer
    load(256'd1, 256'd2, 256'd3, 1'b0, 24);
    wait_result(1'b0);
    unload(256'd3, 256'd3, 1'b0, 1'b0, 16);

    // Zero scalar, then back-to-back k = 5 and k = 7
    load(256'd0, X8, YP, 1'b0, 24);
    wait_result(1'b1);
    unload('0, '0, 1'b0, 1'b1, 16);
    load(256'd5, X8, YP, 1'b0, 24);
    wait_result(1'b0);
    unload(X8P5, YP, 1'b0, 1'b0, 16);
    load(256'd7, X8, YP, 1'b0, 24);
    wait_result(1'b0);
    unload(X8P7, YP, 1'b0, 1'b0, 16);

    // Throttled input and output
    load(256'd1, 256'd2, 256'd3, 1'b1, 24);
    wait_result(1'b0);
    unload(256'd3, 256'd3, 1'b1, 1'b0, 16);

    // Carry across a word boundary
    load(256'hFFFFFFFF, X8, YP, 1'b0, 24);
    wait_result(1'b0);
    unload(X8PC, YP, 1'b0, 1'b0, 16);

    // Reset during LOAD word 12
    load(256'd5, X8, YP, 1'b0, 12);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 32'hBAD0BAD0;
    do_reset();
    load(256'd7, X8, YP, 1'b0, 24);
    wait_result(1'b0);
    unload(X8P7, YP, 1'b0, 1'b0, 16);

    // Reset during RUN
    load(256'd5, X8, YP, 1'b0, 24);
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (10) @(negedge clk);
    check1("run_en_before_rst", core_en, 1'b1);
    do_reset();
    load(256'd1, 256'd2, 256'd3, 1'b0, 24);
    wait_result(1'b0);
    unload(256'd3, 256'd3, 1'b0, 1'b0, 16);

    // Reset during UNLOAD word 4
    load(256'd5, X8, YP, 1'b0, 24);
    wait_result(1'b0);
    unload(X8P5, YP, 1'b0, 1'b0, 4);
    do_reset();
    load(256'd7, X8, YP, 1'b0, 24);
    wait_result(1'b0);
    unload(X8P7, YP, 1'b0, 1'b0, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sm9_mult_io.md
# sm9_mult_io

Word-serial front end for the SM9 scalar multiplication core. It accepts the scalar k and the base point (x, y) as 32-bit words and assembles them into 256-bit operand registers. It then resets, launches and monitors the core, and streams the resulting point back out as 32-bit words. It sits directly upstream and downstream of the scalar multiplication unit and is the only block that drives that unit's en, l, x0 and y0.

## Interface
- No parameters. The word width (32), operand width (256) and word counts are fixed.
- clk  in  1  system clock; all logic is rising-edge.
- rst_b  in  1  synchronous, active-high reset. The port keeps the codebase name, but the polarity here is high-active.
- wr_valid  in  1  input word valid.
- wr_ready  out  1  block accepts an input word.
- wr_data  in  32  input word.
- rd_valid  out  1  output word valid.
- rd_ready  in  1  consumer accepts an output word.
- rd_data  out  32  output word.
- busy  out  1  high from CHECK through the last UNLOAD handshake.
- err  out  1  the result being unloaded is invalid because k == 0.
- core_rst_b  out  1  active-low reset to the core.
- core_en  out  1  core start, held high for the whole run.
- core_l, core_x0, core_y0  out  256  operand registers.
- core_x1, core_y1  in  256  core result.
- core_sign  in  1  core done level; it stays high until the core is reset.

## Operation
- States: LOAD, CHECK, CRST, RUN, CAPTURE, UNLOAD.
- Reset: state enters LOAD. Word counter, rd_valid, core_en, busy and err go to 0. core_rst_b is 0 while rst_b = 1 and returns to 1 in the first cycle after reset releases. Operand and result registers go to 0.
- LOAD:
  - wr_ready = 1. One word is accepted per wr_valid & wr_ready cycle.
  - Word order: words 0–7 = k, 8–15 = x, 16–23 = y, most-significant word first. Word 0 maps to bits [255:224].
  - Accepting word 0 clears err.
  - After word 23 is accepted, the state moves to CHECK.
- CHECK (1 cycle):
  - If core_l == 0: result registers are cleared to 0, err is set to 1, and the state goes to UNLOAD. The core would never terminate on a zero scalar, so it is not launched.
  - Otherwise the state goes to CRST.
- CRST (2 cycles): core_rst_b = 0. This clears the sticky core_sign left by the previous run.
- RUN:
  - core_en = 1 for the entire state.
  - core_l, core_x0 and core_y0 are held constant.
  - The state stays in RUN until core_sign = 1, then moves to CAPTURE.
- CAPTURE (1 cycle): core_x1 and core_y1 are latched into the result registers, core_en drops to 0, and the state goes to UNLOAD.
- UNLOAD:
  - rd_valid = 1. 16 words are sent: x1 words 0–7, then y1 words 0–7, most-significant word first.
  - The word advances on rd_valid & rd_ready.
  - After word 15 is accepted, the state moves to LOAD with wr_ready = 1 in the next cycle.
- wr_ready is 0 outside LOAD. wr_valid in those states is ignored and causes no data change.
- rd_valid is 0 outside UNLOAD.

## Timing
- All outputs are registered or decoded directly from the state register. There is no combinational path from wr_valid or rd_ready to any output.
- Accepting word 23 at edge n gives CHECK in cycle n+1. Nonzero k then gives CRST in cycles n+2 and n+3, and core_en = 1 from cycle n+4.
- Zero k: rd_valid = 1 in cycle n+2.
- The core_sign rise is sampled at edge m. CAPTURE is in cycle m+1 and the first rd_valid is in cycle m+2.
- Output back-pressure: rd_data and rd_valid stay stable while rd_valid & !rd_ready.
- Input gaps: wr_valid may drop between words. The word counter holds.
- Reset mid-operation, in any state:
  - Partial words are discarded and the core is forced into reset.
  - The block returns to LOAD within one cycle after rst_b falls, and input restarts at word 0.
- The input word counter (0–23) and output word counter (0–15) never wrap within a transaction. Each resets to 0 on entering its state.

## Test plan
- Bench core model: it asserts core_sign 50 cycles after core_en rises and returns core_x1 = core_l + core_x0 (mod 2^256) and core_y1 = core_y0.
- Basic transfer: load k = 1, x = 0x...0002, y = 0x...0003 with no gaps. Required: core_rst_b low for exactly 2 cycles, then core_en high. The 16 output words are seven zero words then 0x00000003, and seven zero words then 0x00000003. err = 0.
- Zero scalar: load k = 0 with any x and y. Required: core_en never rises, rd_valid in cycle n+2, all 16 words 0, err = 1.
- Throttling: random wr_valid gaps, and rd_ready low for 3 cycles on every word. Required: the words are identical to the gap-free run and rd_data is held during stalls.
- Back-to-back runs: two transactions with k = 5 and then k = 7. Required: core_rst_b pulses before each run, the second result is not corrupted by the stale core_sign, and err from a preceding k = 0 run is cleared at the first word.
- Reset mid-operation: assert rst_b during word 12 of LOAD, during RUN, and during UNLOAD word 4. Required: wr_ready = 1 in the cycle after release and core_en = 0. A full reload then produces the correct result.
